// File: rtl/culsans_exit_mailbox.sv
// tohost/fromhost exit mailbox on the peripheral bus.
// Optional watchdog: define CULSANS_EXIT_WATCHDOG_EN.
module culsans_exit_mailbox #(
  parameter int unsigned          AddrWidth      = 64,
  parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(64'h1000_0000),
  parameter logic [31:0]          WatchdogCycles = 32'd10_000_000,
  parameter logic [30:0]          WatchdogCode   = 31'h7FFF_FFF0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic [31:0]          exit_o
);

  typedef enum logic {
    RUN,
    EXITED
  } state_t;

  localparam int unsigned WW = AddrWidth - 3;

  state_t      state_q, state_d;
  logic [31:0] exit_q, exit_d;
  logic [63:0] tohost_q, fromhost_q;
  logic [63:0] to_merged, from_merged;
  logic [63:0] rd_val;
  logic [63:0] rdata_q;
  logic        rvalid_q;
  logic [WW-1:0] word;
  logic        sel_to, sel_from;
  logic        wr_to, wr_from;
  logic        exit_hit;
  logic        unused_addr;

  assign unused_addr = ^addr_i[2:0];
  assign gnt_o       = req_i;

  // Word offset from the base; the byte lane bits never take part.
  assign word     = addr_i[AddrWidth-1:3] - BaseAddr[AddrWidth-1:3];
  assign sel_to   = (word == WW'(0));
  assign sel_from = (word == WW'(1));
  assign wr_to    = req_i & we_i & sel_to;
  assign wr_from  = req_i & we_i & sel_from;

  always_comb begin
    to_merged   = tohost_q;
    from_merged = fromhost_q;
    for (int i = 0; i < 8; i++) begin
      if (be_i[i]) begin
        to_merged[8*i +: 8]   = wdata_i[8*i +: 8];
        from_merged[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_to:   rd_val = tohost_q;
      sel_from: rd_val = fromhost_q;
      default:  rd_val = '0;
    endcase
  end

  assign exit_hit = wr_to & be_i[0] & to_merged[0];

`ifdef CULSANS_EXIT_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        sel_kick;
  logic        kick;
  logic        wdog_expire;

  assign sel_kick    = (word == WW'(2));
  assign kick        = req_i & we_i & sel_kick;
  assign wdog_expire = (state_q == RUN) &&
                       (wdog_q == WatchdogCycles - 32'd1);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == RUN) begin
      wdog_d = kick ? 32'd0 : wdog_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    exit_d  = exit_q;
    unique case (state_q)
      RUN: begin
        if (exit_hit) begin
          state_d = EXITED;
          exit_d  = to_merged[31:0];
        end
`ifdef CULSANS_EXIT_WATCHDOG_EN
        else if (wdog_expire) begin
          state_d = EXITED;
          exit_d  = {WatchdogCode, 1'b1};
        end
`endif
      end
      EXITED: begin
        state_d = EXITED;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      exit_q  <= '0;
    end else begin
      state_q <= state_d;
      exit_q  <= exit_d;
    end
  end

  // Response data is captured before the same-cycle write lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tohost_q   <= '0;
      fromhost_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= req_i;
      if (req_i) begin
        rdata_q <= rd_val;
      end
      if (wr_to) begin
        tohost_q <= to_merged;
      end
      if (wr_from) begin
        fromhost_q <= from_merged;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign exit_o   = exit_q;

endmodule

// File: tb/tb_culsans_exit_mailbox.sv
// Scoreboard bench for culsans_exit_mailbox.
// Directed cases followed by randomized traffic.
module tb_culsans_exit_mailbox;

  localparam logic [63:0] BASE = 64'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic [31:0] ex;

  culsans_exit_mailbox dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .gnt_o   (gnt),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .exit_o  (ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [63:0] rdata;
    logic [31:0] exitv;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;

  logic [63:0] m_to;
  logic [63:0] m_from;
  bit          m_exited;
  logic [31:0] m_exit;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_to     = '0;
    m_from   = '0;
    m_exited = 1'b0;
    m_exit   = '0;
    sb.delete();
  endtask

  task automatic do_req(bit w, logic [63:0] a, logic [63:0] d,
                        logic [7:0] b);
    logic [63:0] off;
    logic [63:0] old;
    logic [63:0] nv;
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    off = {a[63:3], 3'b000} - BASE;
    if (off == 64'd0)      old = m_to;
    else if (off == 64'd8) old = m_from;
    else                   old = '0;
    nv = old;
    for (int i = 0; i < 8; i++)
      if (b[i]) nv[8*i +: 8] = d[8*i +: 8];
    if (w && off == 64'd0) begin
      m_to = nv;
      if (!m_exited && b[0] && nv[0]) begin
        m_exited = 1'b1;
        m_exit   = nv[31:0];
      end
    end else if (w && off == 64'd8) begin
      m_from = nv;
    end
    sb.push_back('{!w, old, m_exit});
    #1 chk("gnt", {63'd0, gnt}, 64'd1);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
    #1 chk("gnt_idle", {63'd0, gnt}, 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Responses are due exactly one cycle after the grant.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid", {63'd0, rvalid}, 64'd1);
      if (e.is_rd) chk("rdata", rdata, e.rdata);
      chk("exit", {32'd0, ex}, {32'd0, e.exitv});
    end else begin
      chk("rvalid_idle", {63'd0, rvalid}, 64'd0);
      chk("exit_hold", {32'd0, ex}, {32'd0, m_exit});
    end
  end

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_exit", {32'd0, ex}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1'b1, BASE, 64'h1, 8'hFF);
    idle(1);
    chk("t1_exit", {32'd0, ex}, 64'h1);
    idle(100);
    chk("t1_hold", {32'd0, ex}, 64'h1);

    reset_dut();
    do_req(1'b1, BASE, 64'h7, 8'hFF);
    do_req(1'b1, BASE, 64'h1, 8'hFF);
    do_req(1'b0, BASE, 64'h0, 8'h00);
    idle(1);
    chk("t2_exit", {32'd0, ex}, 64'h7);
    chk("t2_rd", rdata, 64'h1);

    reset_dut();
    do_req(1'b1, BASE, 64'hAB00, 8'h02);
    idle(1);
    chk("t3_noexit", {32'd0, ex}, 64'h0);
    do_req(1'b1, BASE, 64'h01, 8'h01);
    idle(1);
    chk("t3_exit", {32'd0, ex}, 64'hAB01);

    reset_dut();
    do_req(1'b1, BASE + 64'h8, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    do_req(1'b0, BASE + 64'hC, 64'h0, 8'h00);
    idle(1);
    chk("t4_from", rdata, 64'hDEAD_BEEF_0000_0001);
    do_req(1'b1, BASE + 64'h10, 64'h1, 8'hFF);
    do_req(1'b0, BASE + 64'h18, 64'h0, 8'h00);
    idle(1);
    chk("t4_unmapped", rdata, 64'h0);
    chk("t4_exit", {32'd0, ex}, 64'h0);

    reset_dut();
    do_req(1'b1, BASE, 64'h3, 8'hFF);
    do_req(1'b0, BASE, 64'h0, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_rvalid", {63'd0, rvalid}, 64'd0);
    chk("t5_exit", {32'd0, ex}, 64'd0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b1, BASE, 64'h5, 8'hFF);
    do_req(1'b0, BASE, 64'h0, 8'h00);
    idle(1);
    chk("t5_after", {32'd0, ex}, 64'h5);
    chk("t5_rd", rdata, 64'h5);

    reset_dut();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_dut();
      end else if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
        else a = BASE + 64'($urandom_range(0, 31));
        d = {$urandom, $urandom};
        if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
        do_req(1'($urandom_range(0, 1)), a, d, 8'($urandom));
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
